mem_bus_arbiter: RTL and testbench

//   Shares the single data-memory/MMIO port (RAM + timer/led/switch/digi regs) between

---
 rtl/mem_bus_arbiter.sv | 118 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the data-memory/MMIO port: the CPU has priority, and a starvation
// counter guarantees the DMA master a slot. Optional macro ARB_MMIO_LOCK_EN blocks master 1 from MMIO.
module mem_bus_arbiter #(
    parameter int unsigned StarveMax = 4,
    parameter int unsigned CntW      = 3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        m0_read_i,
    input  logic        m0_write_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic [31:0] m0_rdata_o,
    output logic        m0_stall_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_gnt_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_rvalid_o,
`ifdef ARB_MMIO_LOCK_EN
    output logic        m1_err_o,
`endif
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [CntW-1:0] StarveMaxC = CntW'(StarveMax);

    typedef enum logic [0:0] {StIdle, StM1Xfer} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic [31:0]     m1_rdata_q;
    logic            m1_rvalid_q;
    logic            m0_act;
    logic            m1_slot;
    logic            m1_blocked;

    assign m0_act  = m0_read_i | m0_write_i;
    assign m1_slot = (state_q == StM1Xfer);

`ifdef ARB_MMIO_LOCK_EN
    logic m1_err_q;

    // Timer/led/switch/digi register window, inclusive of the last register.
    assign m1_blocked = (m1_addr_i >= 32'h4000_0000) && (m1_addr_i <= 32'h4000_0014);
    assign m1_err_o   = m1_err_q;
`else
    assign m1_blocked = 1'b0;
`endif

    always_comb begin
        state_d    = StIdle;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (m1_req_i && (!m0_act || wait_cnt_q == StarveMaxC)) begin
                    state_d    = StM1Xfer;
                    wait_cnt_d = '0;
                end else if (!m1_req_i) begin
                    wait_cnt_d = '0;
                end else if (wait_cnt_q != StarveMaxC) begin
                    wait_cnt_d = wait_cnt_q + CntW'(1);
                end
            end
            StM1Xfer: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        if (m1_slot) begin
            mem_addr_o  = m1_addr_i;
            mem_wdata_o = m1_wdata_i;
            mem_read_o  = ~m1_we_i & ~m1_blocked;
            mem_write_o = m1_we_i & ~m1_blocked;
        end else begin
            mem_addr_o  = m0_addr_i;
            mem_wdata_o = m0_wdata_i;
            mem_read_o  = m0_read_i;
            mem_write_o = m0_write_i;
        end
    end

    assign m1_gnt_o    = m1_slot;
    assign m0_stall_o  = m1_slot & m0_act;
    assign m0_rdata_o  = mem_rdata_i;
    assign m1_rdata_o  = m1_rdata_q;
    assign m1_rvalid_o = m1_rvalid_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            wait_cnt_q  <= '0;
            m1_rdata_q  <= '0;
            m1_rvalid_q <= 1'b0;
`ifdef ARB_MMIO_LOCK_EN
            m1_err_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            m1_rvalid_q <= m1_slot & ~m1_we_i;
            if (m1_slot && !m1_we_i) begin
                m1_rdata_q <= m1_blocked ? 32'h0 : mem_rdata_i;
            end
`ifdef ARB_MMIO_LOCK_EN
            m1_err_q    <= m1_slot & m1_blocked;
`endif
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a cycle-level reference model pushes expected outputs
// per cycle, and a separate monitor pops and compares them against the DUT.
module tb_mem_bus_arbiter;

    localparam int unsigned StarveMax = 4;
    localparam int unsigned CntW      = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_read = 1'b0, m0_write = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m0_rdata;
    logic        m0_stall;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0, m1_rdata;
    logic        m1_gnt, m1_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;
    logic        m1_err;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.StarveMax(StarveMax), .CntW(CntW)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .m0_read_i  (m0_read),
        .m0_write_i (m0_write),
        .m0_addr_i  (m0_addr),
        .m0_wdata_i (m0_wdata),
        .m0_rdata_o (m0_rdata),
        .m0_stall_o (m0_stall),
        .m1_req_i   (m1_req),
        .m1_we_i    (m1_we),
        .m1_addr_i  (m1_addr),
        .m1_wdata_i (m1_wdata),
        .m1_gnt_o   (m1_gnt),
        .m1_rdata_o (m1_rdata),
        .m1_rvalid_o(m1_rvalid),
`ifdef ARB_MMIO_LOCK_EN
        .m1_err_o   (m1_err),
`endif
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_read_o (mem_read),
        .mem_write_o(mem_write),
        .mem_rdata_i(mem_rdata)
    );

`ifndef ARB_MMIO_LOCK_EN
    assign m1_err = 1'b0;
`endif

    // Environment memory: 16 words aliased on addr[5:2], combinational read, posedge write.
    logic [31:0] env_mem [16];
    logic        env_ready = 1'b0;
    assign mem_rdata = env_mem[mem_addr[5:2]];
    always @(posedge clk) begin
        if (!env_ready) begin
            for (int i = 0; i < 16; i++) env_mem[i] <= 32'h1000 + 32'(i);
        end else if (mem_write) begin
            env_mem[mem_addr[5:2]] <= mem_wdata;
        end
    end

    typedef struct {
        logic        gnt, stall, mrd, mwr, rv, err, chk_m0;
        logic [31:0] maddr, mwd, rdata, m0d;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0, n_bad = 0, gnt_seen = 0;

    // Reference model state
    logic [31:0] ref_mem [16];
    bit          mx;        // current cycle is an m1 slot
    int          mw;        // cycles m1 has waited behind the CPU
    bit          mrv, merr;
    logic [31:0] mrd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit blocked(input logic [31:0] a);
`ifdef ARB_MMIO_LOCK_EN
        return (a >= 32'h4000_0000) && (a <= 32'h4000_0014);
`else
        return (a[31:0] == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    task automatic model_reset();
        mx = 0; mw = 0; mrv = 0; merr = 0; mrd = '0;
    endtask

    task automatic cycle(input logic rd, input logic wr, input logic [31:0] a0,
                         input logic [31:0] d0, input logic req, input logic we,
                         input logic [31:0] a1, input logic [31:0] d1);
        exp_t e;
        @(negedge clk);
        m0_read = rd; m0_write = wr; m0_addr = a0; m0_wdata = d0;
        m1_req = req; m1_we = we; m1_addr = a1; m1_wdata = d1;
        e.gnt    = mx;
        e.stall  = mx && (rd || wr);
        e.maddr  = mx ? a1 : a0;
        e.mwd    = mx ? d1 : d0;
        e.mrd    = mx ? (!we && !blocked(a1)) : rd;
        e.mwr    = mx ? (we && !blocked(a1)) : wr;
        e.rv     = mrv;
        e.rdata  = mrd;
        e.err    = merr;
        e.chk_m0 = !mx && rd;
        e.m0d    = ref_mem[a0[5:2]];
        exp_q.push_back(e);
        if (mx) begin
            mrv  = !we;
            merr = blocked(a1);
            if (!we) mrd = blocked(a1) ? 32'h0 : ref_mem[a1[5:2]];
            else if (!blocked(a1)) ref_mem[a1[5:2]] = d1;
            mx = 0;
        end else begin
            mrv = 0; merr = 0;
            if (wr) ref_mem[a0[5:2]] = d0;
            if (req && (!(rd || wr) || mw == StarveMax)) begin
                mx = 1; mw = 0;
            end else if (!req) begin
                mw = 0;
            end else if (mw < StarveMax) begin
                mw++;
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("m1_gnt", m1_gnt, e.gnt);
                chk("m0_stall", m0_stall, e.stall);
                chk("mem_addr", mem_addr, e.maddr);
                chk("mem_wdata", mem_wdata, e.mwd);
                chk("mem_read", mem_read, e.mrd);
                chk("mem_write", mem_write, e.mwr);
                chk("m1_rvalid", m1_rvalid, e.rv);
                if (e.rv) chk("m1_rdata", m1_rdata, e.rdata);
                chk("m1_err", m1_err, e.err);
                if (e.chk_m0) chk("m0_rdata", m0_rdata, e.m0d);
                if (m1_gnt) gnt_seen++;
            end
        end
    end

    initial begin : stim
        bit          pend, p_we, was_x;
        logic [31:0] p_a, p_d, a0;
        int          op, g0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h1000 + 32'(i);
        model_reset();
        m0_read = 1'b1; m0_addr = 32'h44; m1_req = 1'b1; m1_addr = 32'h8;
        repeat (3) @(posedge clk);
        env_ready = 1'b1;
        #1;
        chk("rst_gnt", m1_gnt, 0);
        chk("rst_rvalid", m1_rvalid, 0);
        chk("rst_rdata", m1_rdata, 0);
        chk("rst_stall", m0_stall, 0);
        chk("rst_mem_addr", mem_addr, 32'h44);
        chk("rst_mem_read", mem_read, 1);
        @(negedge clk);
        m0_read = 1'b0; m1_req = 1'b0;
        rst_n = 1'b1;

        // Reset arriving mid-transfer aborts the write
        repeat (2) cycle(0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 1, 32'h20, 32'hDEADBEEF);
        @(negedge clk);
        #1;
        chk("pre_rst_gnt", m1_gnt, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_gnt", m1_gnt, 0);
        chk("rst_mid_write", mem_write, 0);
        chk("rst_mid_rvalid", m1_rvalid, 0);
        m1_req = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_no_commit", env_mem[8], ref_mem[8]);
        chk("rst_rvalid_after", m1_rvalid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // m1 write then read-back with CPU idle
        repeat (2) cycle(0, 0, 0, 0, 1, 1, 32'h8, 32'h1234);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) cycle(0, 0, 0, 0, 1, 0, 32'h8, 0);
        repeat (2) cycle(0, 0, 0, 0, 0, 0, 0, 0);

        // CPU reads every cycle, m1 held: forced slot after StarveMax waits
        for (int i = 0; i < 8; i++) cycle(1, 0, 32'h8, 0, (i < 6), 0, 32'h10, 0);
        repeat (2) cycle(0, 0, 0, 0, 0, 0, 0, 0);

        // m1 held 10 cycles with CPU idle: grants on alternate cycles
        #2;
        g0 = gnt_seen;
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 1, 0, 32'h4, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("alt_grants", 32'(gnt_seen - g0), 5);

        // Withdrawn request under load, then a fresh starvation run
        repeat (2) cycle(1, 0, 32'hC, 0, 1, 1, 32'h14, 32'h55);
        repeat (2) cycle(1, 0, 32'hC, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) cycle(0, 1, 32'h18, 32'(i), (i < 6), 1, 32'h1C, 32'hA5);

        // Randomized traffic
        pend = 0; p_we = 0; p_a = 0; p_d = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!pend && $urandom_range(0, 2) == 0) begin
                pend = 1;
                p_we = 1'($urandom);
                p_a  = {26'h0, 4'($urandom), 2'b00};
`ifdef ARB_MMIO_LOCK_EN
                if ($urandom_range(0, 3) == 0) p_a = 32'h4000_0000 | {27'h0, 3'($urandom), 2'b00};
`endif
                p_d  = $urandom;
            end else if (pend && !mx && $urandom_range(0, 15) == 0) begin
                pend = 0;
            end
            op = int'($urandom_range(0, 3));
            a0 = {26'h0, 4'($urandom), 2'b00};
            was_x = mx;
            cycle(op == 1 || op == 3, op == 2, a0, $urandom, pend, p_we, p_a, p_d);
            if (was_x) pend = 0;
        end
        repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
